// File: rtl/dm_bus_responder.sv
// rtl/dm_bus_responder.sv - handshaked data-memory slave with programmable wait states
//
// Purpose: data-memory responder for the CPU data port. A request is latched
// in IDLE, held for WAIT_CYCLES wait states, then answered with a one-cycle
// ready strobe carrying registered rdata/err. Supports byte-enabled stores
// and reports misaligned or out-of-window addresses.
//
// Ports:
//   clk    in   1   system clock, rising edge
//   rst    in   1   asynchronous active-low reset
//   req    in   1   request valid, held stable until ready
//   we     in   1   1 = store, 0 = load
//   addr   in  32   byte address
//   wdata  in  32   store data
//   be     in   4   store byte enables (be[0] = bits 7:0)
//   rdata  out 32   load data, valid while ready = 1
//   ready  out  1   one-cycle response strobe
//   err    out  1   error flag, valid while ready = 1
//   busy   out  1   high whenever the FSM is not idle
module dm_bus_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  // Window size kept at 33 bits so a window reaching 4 GiB cannot overflow.
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            lat_we_q, lat_we_d;
  logic [31:0]     lat_wdata_q, lat_wdata_d;
  logic [3:0]      lat_be_q, lat_be_d;
  logic [AW-1:0]   lat_idx_q, lat_idx_d;
  logic            err_pend_q, err_pend_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     mem_q [DEPTH_WORDS];
  logic [31:0]     mem_d [DEPTH_WORDS];

  logic [31:0]     off_in;
  logic [AW-1:0]   idx_in;
  logic            err_in;

  // Decode of the live request; only used in the accepting cycle.
  always_comb begin
    off_in = addr - BASE_ADDR;
    idx_in = off_in[AW+1:2];
    err_in = (addr[1:0] != 2'b00) || (addr < BASE_ADDR) || ({1'b0, off_in} >= SPAN);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_we_d    = lat_we_q;
    lat_wdata_d = lat_wdata_q;
    lat_be_d    = lat_be_q;
    lat_idx_d   = lat_idx_q;
    err_pend_d  = err_pend_q;
    ready_d     = 1'b0;
    err_d       = 1'b0;
    rdata_d     = '0;
    mem_d       = mem_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          lat_we_d    = we;
          lat_wdata_d = wdata;
          lat_be_d    = be;
          lat_idx_d   = idx_in;
          err_pend_d  = err_in;
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            // No wait states: response flops load straight from the live request.
            state_d = S_RESP;
            ready_d = 1'b1;
            err_d   = err_in;
            if (!we && !err_in) begin
              rdata_d = mem_q[idx_in];
            end
          end
        end
      end

      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
          ready_d = 1'b1;
          err_d   = err_pend_q;
          if (!lat_we_q && !err_pend_q) begin
            rdata_d = mem_q[lat_idx_q];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
        // Store commits at the edge ending RESP, so a load accepted in the
        // following IDLE cycle already sees the new data.
        if (lat_we_q && !err_pend_q) begin
          for (int b = 0; b < 4; b++) begin
            if (lat_be_q[b]) begin
              mem_d[lat_idx_q][8*b +: 8] = lat_wdata_q[8*b +: 8];
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lat_we_q    <= 1'b0;
      lat_wdata_q <= '0;
      lat_be_q    <= '0;
      lat_idx_q   <= '0;
      err_pend_q  <= 1'b0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_we_q    <= lat_we_d;
      lat_wdata_q <= lat_wdata_d;
      lat_be_q    <= lat_be_d;
      lat_idx_q   <= lat_idx_d;
      err_pend_q  <= err_pend_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      mem_q       <= mem_d;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_dm_bus_responder.sv
// tb/tb_dm_bus_responder.sv - scoreboard bench for dm_bus_responder (2 and 0 wait states)
module tb_dm_bus_responder;

  logic        clk;
  logic        rst   [2];
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  be    [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        err   [2];
  logic        busy  [2];

  int n_cmp = 0;
  int n_bad = 0;

  // Expected responses as {err, rdata}.
  logic [32:0] q0 [$];
  logic [32:0] q1 [$];

  dm_bus_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut_w2 (
    .clk(clk), .rst(rst[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .be(be[0]), .rdata(rdata[0]), .ready(ready[0]),
    .err(err[0]), .busy(busy[0])
  );

  dm_bus_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut_w0 (
    .clk(clk), .rst(rst[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .be(be[1]), .rdata(rdata[1]), .ready(ready[1]),
    .err(err[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitors: pop and compare on every ready strobe.
  always @(negedge clk) begin
    if (ready[0] === 1'b1) begin
      n_cmp++;
      if (q0.size() == 0) begin
        n_bad++;
        $display("FAIL resp_w2 unexpected ready: err=%0b rdata=0x%08h", err[0], rdata[0]);
      end else begin
        logic [32:0] e;
        e = q0.pop_front();
        if ({err[0], rdata[0]} !== e) begin
          n_bad++;
          $display("FAIL resp_w2: got err=%0b rdata=0x%08h expected err=%0b rdata=0x%08h",
                   err[0], rdata[0], e[32], e[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (ready[1] === 1'b1) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_bad++;
        $display("FAIL resp_w0 unexpected ready: err=%0b rdata=0x%08h", err[1], rdata[1]);
      end else begin
        logic [32:0] e;
        e = q1.pop_front();
        if ({err[1], rdata[1]} !== e) begin
          n_bad++;
          $display("FAIL resp_w0: got err=%0b rdata=0x%08h expected err=%0b rdata=0x%08h",
                   err[1], rdata[1], e[32], e[31:0]);
        end
      end
    end
  end

  // One transaction on instance i; checks latency and busy length.
  task automatic txn(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic e_err, input logic [31:0] e_rdata);
    int cyc;
    int nbusy;
    int lat;
    bit seen;
    lat   = (i == 0) ? 3 : 1;
    cyc   = 0;
    nbusy = 0;
    seen  = 0;
    if (i == 0) q0.push_back({e_err, e_rdata});
    else        q1.push_back({e_err, e_rdata});
    @(negedge clk);
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d; be[i] = b;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy[i]) nbusy++;
      if (ready[i]) seen = 1;
    end
    req[i] = 1'b0;
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL txn_timeout: inst=%0d addr=0x%08h no ready within 40 cycles", i, a);
    end else begin
      check($sformatf("latency_i%0d_a%08h", i, a), 32'(cyc), 32'(lat));
      check($sformatf("busy_len_i%0d_a%08h", i, a), 32'(nbusy), 32'(lat));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0; req[i] = 1'b0; we[i] = 1'b0;
      addr[i] = '0; wdata[i] = '0; be[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(ready[0]), 32'd0);
    check("reset_err",   32'(err[0]),   32'd0);
    check("reset_rdata", rdata[0],      32'd0);
    check("reset_busy",  32'(busy[0]),  32'd0);
    check("reset_busy0", 32'(busy[1]),  32'd0);
    rst[0] = 1'b1; rst[1] = 1'b1;
    @(negedge clk);

    // 1. load after reset
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'h0);
    @(negedge clk);
    check("busy_after_resp", 32'(busy[0]), 32'd0);
    check("ready_after_resp", 32'(ready[0]), 32'd0);

    // 2. full store then load
    txn(0, 1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);

    // 3. partial store then load
    txn(0, 1'b1, 32'h20, 32'h11223344, 4'b0101, 1'b0, 32'h0);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'hDE22BE44);

    // be = 0 store leaves memory untouched
    txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'h0);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'hDE22BE44);

    // 4. errors
    txn(0, 1'b1, 32'h3FC, 32'h0BADF00D, 4'hF, 1'b0, 32'h0);
    txn(0, 1'b0, 32'h22, 32'h0, 4'h0, 1'b1, 32'h0);
    txn(0, 1'b1, 32'h400, 32'h55555555, 4'hF, 1'b1, 32'h0);
    txn(0, 1'b1, 32'h3FE, 32'h66666666, 4'hF, 1'b1, 32'h0);
    txn(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 1'b0, 32'h0BADF00D);
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    txn(0, 1'b0, 32'h400, 32'h0, 4'h0, 1'b1, 32'h0);

    // 5. zero wait states, req held across two loads
    txn(1, 1'b1, 32'h100, 32'hA5A50001, 4'hF, 1'b0, 32'h0);
    txn(1, 1'b1, 32'h104, 32'h5A5A0002, 4'hF, 1'b0, 32'h0);
    txn(1, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 32'hA5A50001);
    q1.push_back({1'b0, 32'hA5A50001});
    q1.push_back({1'b0, 32'h5A5A0002});
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h100;
    @(negedge clk);
    check("w0_pulse1", 32'(ready[1]), 32'd1);
    addr[1] = 32'h104;
    @(negedge clk);
    check("w0_gap_ready", 32'(ready[1]), 32'd0);
    check("w0_gap_busy",  32'(busy[1]),  32'd0);
    @(negedge clk);
    check("w0_pulse2", 32'(ready[1]), 32'd1);
    req[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("w0_idle_ready", 32'(ready[1]), 32'd0);
      check("w0_idle_busy",  32'(busy[1]),  32'd0);
    end

    // 6. reset in the middle of a store
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'hCAFEF00D; be[0] = 4'hF;
    @(negedge clk);
    check("mid_busy_wait", 32'(busy[0]), 32'd1);
    rst[0] = 1'b0;
    req[0] = 1'b0;
    #1;
    check("mid_busy_async", 32'(busy[0]), 32'd0);
    @(negedge clk);
    rst[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("mid_no_ready", 32'(ready[0]), 32'd0);
      check("mid_no_busy",  32'(busy[0]),  32'd0);
    end
    txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 32'h0);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, 32'h0);
    // store immediately followed by load after reset recovery
    txn(0, 1'b1, 32'h40, 32'h12345678, 4'b1000, 1'b0, 32'h0);
    txn(0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 32'h12000000);

    repeat (3) @(negedge clk);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
